ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
// - Two-requester arbiter/sequencer for the single-port 16-bit RAM (clk/we/addr/din/dout).
// - Latches one request, drives the RAM for one access, waits out read latency, returns data + ack pulse.
// - Sits between the RAM and two masters (port 0 = CPU/datapath, port 1 = secondary/DMA-style master).
// PARAMETERS
// - DATA_W  16  data width of RAM and both ports
// - ADDR_W  16  address width of RAM and both ports
// - RD_LAT  1   RAM read latency in cycles after address edge; legal 0..3 (0 = async read)
// PORTS
// - clk       in   1       system clock, all logic on rising edge
// - reset     in   1       synchronous, active-high reset
// - req0/req1   in   1       request; hold high with we/addr/din stable until ack
// - we0/we1     in   1       1 = write, 0 = read
// - addr0/addr1 in   ADDR_W  access address
// - din0/din1   in   DATA_W  write data
// - ack0/ack1   out  1       one-cycle completion pulse
// - dout0/dout1 out  DATA_W  read data, valid in ack cycle, held until next read ack on that port
// - ram_we    out  1       RAM write enable
// - ram_addr  out  ADDR_W  RAM address
// - ram_din   out  DATA_W  RAM write data
// - ram_dout  in   DATA_W  RAM read data
// - busy      out  1       high in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE; ack0/1=0, dout0/1=0, ram_we=0, ram_addr=0, ram_din=0, busy=0, wait count=0.
// - FSM: IDLE, ISSUE, WAIT, ACK.
// - IDLE: on edge with any req high, pick winner; latch sel/we/addr/din into regs; -> ISSUE.
// - Priority: port 0 wins on simultaneous req (fixed priority, no macro). Lone req always wins.
// - ISSUE (1 cycle): ram_addr/ram_din from latched regs; ram_we = latched we.
// - Write: ISSUE -> ACK.
// - Read: RD_LAT=0 -> ACK, capture ram_dout at ISSUE exit. RD_LAT>0 -> WAIT for RD_LAT cycles.
// - Read in WAIT: capture ram_dout at the edge leaving the last WAIT cycle.
// - Captured data loads dout of the selected port only; other port's dout unchanged.
// - ACK (1 cycle): ack of selected port = 1; -> IDLE. Never both acks high.
// - Write latency: req edge E0 -> ISSUE -> ack high in cycle after E1.
// - Read latency: ack high in cycle after edge E(1+RD_LAT).
// - Min one IDLE cycle between transactions.
// - If req still high in IDLE after ack, it is a new request.
// - ram_we is high only in ISSUE, max 1 cycle per write. ram_addr/ram_din hold last values when idle.
// - Req dropped mid-transaction: access still completes; ack still pulses.
// - Requester inputs changing mid-transaction: ignored, latched copy is used.
// - Reset mid-operation: next edge returns to IDLE, ram_we=0. Pending ack is not issued; dout cleared.
// - Address/data pass through unmodified, no wrap logic; WAIT counter is 2 bits.
// CONFIGURATION
// - Macro ARB_ROUND_ROBIN_EN.
// - Defined: round-robin. last_gnt reg, reset to 1 so port 0 wins first contention.
//   On simultaneous req, the port != last_gnt wins. last_gnt updates on every grant.
// - Undefined: fixed priority, port 0 always wins; no last_gnt reg exists.
// TESTING
// - T1 reset, req0 we0=1 addr0=16'h0010 din0=16'hBEEF -> ram_we 1 cycle @0010; ack0 1 cycle after; ack1=0.
// - T2 RD_LAT=1, req1 read addr1=16'h0010 after T1 -> ack1 at E2+; dout1=16'hBEEF; dout0 unchanged.
// - T3 req0+req1 together, reads of 0x0010/0x0020 -> fixed: port 0 served twice if req0 reasserted.
//   With ARB_ROUND_ROBIN_EN: grants alternate 0,1,0,1.
// - T4 reset asserted in WAIT of read -> no ack; dout0/dout1=0; state IDLE; ram_we=0 next cycle.
// - T5 req0 dropped in ISSUE, addr0 changed -> access uses latched addr; ack0 still pulses once.
// - T6 RD_LAT=0 and RD_LAT=3 read of 16'hFFFF @ addr 16'hFFFF -> ack 2 / 5 cycles after req edge; data correct.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the single-port RAM.
// slave = arbiter side, master = requesters plus RAM side.
interface ram_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] din0;
  logic              ack0;
  logic [DATA_W-1:0] dout0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] din1;
  logic              ack1;
  logic [DATA_W-1:0] dout1;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;

  modport slave (
    input  req0, we0, addr0, din0,
    input  req1, we1, addr1, din1,
    input  ram_dout,
    output ack0, dout0, ack1, dout1,
    output ram_we, ram_addr, ram_din, busy
  );

  modport master (
    output req0, we0, addr0, din0,
    output req1, we1, addr1, din1,
    output ram_dout,
    input  ack0, dout0, ack1, dout1,
    input  ram_we, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a single-port RAM with RD_LAT read latency.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (port 0).
module ram_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_e;

  localparam logic [1:0] WAIT_INIT =
    (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_e            state_q;
  logic              sel_q;
  logic              we_q;
  logic [1:0]        cnt_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] dout0_q;
  logic [DATA_W-1:0] dout1_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              busy_q;

  logic              gnt_d;
  logic              any_req;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] din_d;

  assign any_req = bus.req0 | bus.req1;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt_q;

  assign gnt_d = (bus.req0 & bus.req1) ? ~last_gnt_q : ~bus.req0;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
    end else if (state_q == IDLE && any_req) begin
      last_gnt_q <= gnt_d;
    end
  end
`else
  assign gnt_d = ~bus.req0;
`endif

  assign we_d   = gnt_d ? bus.we1   : bus.we0;
  assign addr_d = gnt_d ? bus.addr1 : bus.addr0;
  assign din_d  = gnt_d ? bus.din1  : bus.din0;

  // ram_addr_q/ram_din_q double as the latched request copy
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 2'd0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      dout0_q    <= '0;
      dout1_q    <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            sel_q      <= gnt_d;
            we_q       <= we_d;
            ram_we_q   <= we_d;
            ram_addr_q <= addr_d;
            ram_din_q  <= din_d;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          ram_we_q <= 1'b0;
          if (we_q || RD_LAT == 0) begin
            if (!we_q) begin
              if (sel_q) dout1_q <= bus.ram_dout;
              else       dout0_q <= bus.ram_dout;
            end
            ack0_q  <= ~sel_q;
            ack1_q  <= sel_q;
            state_q <= ACK;
          end else begin
            cnt_q   <= WAIT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            if (sel_q) dout1_q <= bus.ram_dout;
            else       dout0_q <= bus.ram_dout;
            ack0_q  <= ~sel_q;
            ack1_q  <= sel_q;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.dout0    = dout0_q;
  assign bus.dout1    = dout1_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: RAM model plus transaction-level reference.
// Honors ARB_ROUND_ROBIN_EN the same way the design does.
module tb_ram_arbiter;
  parameter int RD_LAT = 1;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  ram_arbiter #(
    .DATA_W (16),
    .ADDR_W (16),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // physical RAM with RD_LAT-stage read pipeline
  logic [15:0] mem  [0:65535];
  logic [15:0] pipe [0:3];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    pipe[0] <= mem[bus.ram_addr];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end

  generate
    if (RD_LAT == 0) begin : g_async
      assign bus.ram_dout = mem[bus.ram_addr];
    end else begin : g_sync
      assign bus.ram_dout = pipe[RD_LAT-1];
    end
  endgenerate

  // reference state
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_dout0 = 16'h0;
  logic [15:0] exp_dout1 = 16'h0;
  bit          last_gnt  = 1'b1;
  logic [15:0] pool [8] = '{16'h0010, 16'h0020, 16'hFFFF, 16'h0000,
                            16'h1234, 16'h8000, 16'h00FF, 16'hABCD};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic txn(input bit r0, input bit r1,
                     input bit w0, input bit w1,
                     input logic [15:0] a0, input logic [15:0] a1,
                     input logic [15:0] d0, input logic [15:0] d1,
                     input bit scr, input bit keep);
    bit          win;
    bit          wwe;
    logic [15:0] wa;
    logic [15:0] wd;
    int          n;
    int          wec;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.din0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.din1 = d1;
    if (r0 && r1) win = RR ? ~last_gnt : 1'b0;
    else          win = !r0;
    last_gnt = win;
    wwe = win ? w1 : w0;
    wa  = win ? a1 : a0;
    wd  = win ? d1 : d0;
    @(posedge clk); #1;
    n   = 1;
    wec = int'(bus.ram_we);
    chk("issue_we", 32'(bus.ram_we), 32'(wwe));
    chk("issue_addr", 32'(bus.ram_addr), 32'(wa));
    if (wwe) chk("issue_din", 32'(bus.ram_din), 32'(wd));
    chk("busy", 32'(bus.busy), 32'd1);
    if (scr) begin
      bus.req0  = 1'b0;       bus.req1  = 1'b0;
      bus.addr0 = 16'($urandom); bus.addr1 = 16'($urandom);
      bus.din0  = 16'($urandom); bus.din1  = 16'($urandom);
      bus.we0   = ~w0;        bus.we1   = ~w1;
    end
    while (!(bus.ack0 || bus.ack1) && n < 12) begin
      @(posedge clk); #1;
      n++;
      wec += int'(bus.ram_we);
    end
    chk("latency", 32'(n), wwe ? 32'd2 : 32'(2 + RD_LAT));
    chk("ack_sel", {30'd0, bus.ack1, bus.ack0}, win ? 32'd2 : 32'd1);
    chk("we_pulses", 32'(wec), wwe ? 32'd1 : 32'd0);
    if (wwe)      ref_mem[wa] = wd;
    else if (win) exp_dout1 = ref_mem[wa];
    else          exp_dout0 = ref_mem[wa];
    chk("dout0", 32'(bus.dout0), 32'(exp_dout0));
    chk("dout1", 32'(bus.dout1), 32'(exp_dout1));
    if (!keep) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    @(posedge clk); #1;
    chk("ack_clr", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.din0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.din1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("rst_dout0", 32'(bus.dout0), 32'd0);
    chk("rst_dout1", 32'(bus.dout1), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_din", 32'(bus.ram_din), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (pool[i])
      txn(1, 0, 1, 0, pool[i], 16'h0, 16'($urandom), 16'h0, 0, 0);

    // T1 / T2
    txn(1, 0, 1, 0, 16'h0010, 16'h0, 16'hBEEF, 16'h0, 0, 0);
    txn(0, 1, 0, 0, 16'h0, 16'h0010, 16'h0, 16'h0, 0, 0);
    chk("t2_dout1", 32'(bus.dout1), 32'h0000BEEF);

    // T3: contention with requests held across acks
    for (int k = 0; k < 4; k++)
      txn(1, 1, 0, 0, 16'h0010, 16'h0020, 16'h0, 16'h0, 0, k != 3);

    // T5: requester drops and scrambles after latch
    txn(1, 0, 0, 0, 16'h0020, 16'h0, 16'h0, 16'h0, 1, 0);
    txn(0, 1, 1, 0, 16'h0, 16'h1234, 16'h0, 16'h5A5A, 1, 0);

    // T6
    txn(1, 0, 1, 0, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 0, 0);
    txn(0, 1, 0, 0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 0, 0);
    chk("t6_dout1", 32'(bus.dout1), 32'h0000FFFF);

    for (int k = 0; k < 80; k++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      txn(r0, r1, 1'($urandom), 1'($urandom),
          pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
          16'($urandom), 16'($urandom),
          $urandom_range(0, 3) == 0, 0);
    end

    // T4: reset while a read is in flight
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = pool[4];
    @(posedge clk); #1;
    if (RD_LAT > 0) begin
      @(posedge clk); #1;
    end
    reset    = 1'b1;
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    chk("t4_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("t4_dout0", 32'(bus.dout0), 32'd0);
    chk("t4_dout1", 32'(bus.dout1), 32'd0);
    chk("t4_ram_we", 32'(bus.ram_we), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    exp_dout0 = 16'h0;
    exp_dout1 = 16'h0;
    last_gnt  = 1'b1;
    @(posedge clk); #1;
    chk("t4_no_late_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
    txn(1, 1, 0, 0, 16'h0010, 16'h0020, 16'h0, 16'h0, 0, 0);
    txn(1, 1, 0, 0, 16'h0020, 16'hFFFF, 16'h0, 16'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
